// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state (IDLE waits for a request, LOCKED holds a
//                 grant until the granted requester's last beat is accepted)
//   PktCntW     : width of the released-packet counter
//   calc_idx_w  : width of a requester index, never less than 1 bit
package spi_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   localparam int PktCntW = 16;

   function automatic int calc_idx_w(input int num_req);
      return (num_req <= 2) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/spi_rr_picker.sv
// Combinational round-robin winner selection.
//   req      : request vector, one bit per requester
//   prio_ptr : requester that has highest priority this round
//   winner   : first requester with req set, searching upward from prio_ptr
//              with wrap-around (0 when nothing is requested)
//   any_req  : at least one request is present
// The request vector is duplicated side by side. Bits below prio_ptr in the
// lower copy are masked off, so the lowest set bit of the doubled vector is
// the first requester at or after prio_ptr; the upper copy supplies the
// wrapped part of the search.
module spi_rr_picker #(
   parameter int NumReq = 4,
   parameter int IdxW   = 2
) (
   input  logic [NumReq-1:0] req,
   input  logic [IdxW-1:0]   prio_ptr,
   output logic [IdxW-1:0]   winner,
   output logic              any_req
);

   logic [2*NumReq-1:0] req_dbl;
   logic [2*NumReq-1:0] masked;

   always_comb begin
      req_dbl = {req, req};
      masked  = '0;
      for (int i = 0; i < 2*NumReq; i++) begin
         masked[i] = req_dbl[i] & (i >= int'(prio_ptr));
      end
   end

   // Scanning downward lets the lowest set bit be the final assignment.
   always_comb begin
      winner = '0;
      for (int i = 2*NumReq-1; i >= 0; i--) begin
         if (masked[i]) begin
            winner = (i >= NumReq) ? IdxW'(i - NumReq) : IdxW'(i);
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/spi_fifo_wr_arbiter.sv
// Packet-locking round-robin arbiter in front of a synchronous FIFO write port.
// Handshake: a beat moves when valid and ready are both high on a rising clk_i
// edge; a requester holds valid, data and last stable until that happens.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   clr_i               : synchronous flush, overrides everything else
//   req_valid_i/last_i  : per-requester beat valid and last-beat flag
//   req_data_i          : packed per-requester data, requester 0 in the LSBs
//   req_ready_o         : per-requester ready, one-hot or zero
//   fifo_wvalid_o/wready_i/wdata_o : FIFO write port
//   fifo_clr_o          : one-cycle FIFO clear, registered from clr_i
//   gnt_idx_o           : current or last granted requester
//   busy_o              : grant is locked
//   state_o, pkt_cnt_o  : debug view of the FSM state and released packets
module spi_fifo_wr_arbiter
   import spi_arb_pkg::*;
#(
   parameter int  NumReq = 4,
   parameter int  Width  = 16,
   localparam int IdxW   = calc_idx_w(NumReq)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clr_i,
   input  logic [NumReq-1:0]       req_valid_i,
   input  logic [NumReq-1:0]       req_last_i,
   input  logic [NumReq*Width-1:0] req_data_i,
   output logic [NumReq-1:0]       req_ready_o,
   output logic                    fifo_wvalid_o,
   input  logic                    fifo_wready_i,
   output logic [Width-1:0]        fifo_wdata_o,
   output logic                    fifo_clr_o,
   output logic [IdxW-1:0]         gnt_idx_o,
   output logic                    busy_o,
   output arb_state_e              state_o,
   output logic [PktCntW-1:0]      pkt_cnt_o
);

   arb_state_e         state_q;
   logic [IdxW-1:0]    prio_ptr_q;
   logic [IdxW-1:0]    gnt_idx_q;
   logic [IdxW-1:0]    winner;
   logic [PktCntW-1:0] pkt_cnt_q;
   logic               any_req;
   logic               clr_q;
   logic               locked;
   logic               beat_acc;
   logic               release_pkt;
   logic [Width-1:0]   data_arr [NumReq];

   for (genvar g = 0; g < NumReq; g++) begin : g_unpack
      assign data_arr[g] = req_data_i[g*Width +: Width];
   end

   spi_rr_picker #(
      .NumReq (NumReq),
      .IdxW   (IdxW)
   ) u_picker (
      .req      (req_valid_i),
      .prio_ptr (prio_ptr_q),
      .winner   (winner),
      .any_req  (any_req)
   );

   assign locked        = (state_q == ARB_LOCKED);
   // clr_i blocks the handshake in its own cycle, so a flush never races a beat.
   assign fifo_wvalid_o = locked & ~clr_i & req_valid_i[gnt_idx_q];
   assign beat_acc      = fifo_wvalid_o & fifo_wready_i;
   assign release_pkt   = beat_acc & req_last_i[gnt_idx_q];
   assign fifo_wdata_o  = fifo_wvalid_o ? data_arr[gnt_idx_q] : '0;

   always_comb begin
      req_ready_o = '0;
      if (locked && !clr_i) begin
         req_ready_o[gnt_idx_q] = fifo_wready_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ARB_IDLE;
         prio_ptr_q <= '0;
         gnt_idx_q  <= '0;
         clr_q      <= 1'b0;
         pkt_cnt_q  <= '0;
      end else if (clr_i) begin
         state_q    <= ARB_IDLE;
         prio_ptr_q <= '0;
         gnt_idx_q  <= '0;
         clr_q      <= 1'b1;
      end else begin
         clr_q <= 1'b0;
         case (state_q)
            ARB_IDLE: begin
               if (any_req) begin
                  gnt_idx_q <= winner;
                  state_q   <= ARB_LOCKED;
               end
            end
            ARB_LOCKED: begin
               if (release_pkt) begin
                  state_q    <= ARB_IDLE;
                  prio_ptr_q <= (gnt_idx_q == IdxW'(NumReq - 1)) ? '0 : gnt_idx_q + 1'b1;
                  pkt_cnt_q  <= pkt_cnt_q + 1'b1;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign fifo_clr_o = clr_q;
   assign gnt_idx_o  = gnt_idx_q;
   assign busy_o     = locked;
   assign state_o    = state_q;
   assign pkt_cnt_o  = pkt_cnt_q;

endmodule

// File: tb/tb_spi_fifo_wr_arbiter.sv
// Directed bench for spi_fifo_wr_arbiter: rotation, packet lock, backpressure,
// valid gap, flush against a last beat, and asynchronous reset.
module tb_spi_fifo_wr_arbiter;
   import spi_arb_pkg::*;

   localparam int NR = 4;
   localparam int W  = 16;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            clr_i;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_last;
   logic [NR*W-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            fifo_wvalid;
   logic            fifo_wready;
   logic [W-1:0]    fifo_wdata;
   logic            fifo_clr;
   logic [1:0]      gnt_idx;
   logic            busy;
   arb_state_e      state;
   logic [15:0]     pkt_cnt;

   int total = 0;
   int bad   = 0;

   spi_fifo_wr_arbiter #(
      .NumReq (NR),
      .Width  (W)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clr_i         (clr_i),
      .req_valid_i   (req_valid),
      .req_last_i    (req_last),
      .req_data_i    (req_data),
      .req_ready_o   (req_ready),
      .fifo_wvalid_o (fifo_wvalid),
      .fifo_wready_i (fifo_wready),
      .fifo_wdata_o  (fifo_wdata),
      .fifo_clr_o    (fifo_clr),
      .gnt_idx_o     (gnt_idx),
      .busy_o        (busy),
      .state_o       (state),
      .pkt_cnt_o     (pkt_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   // ---------------- driver / checker tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic l, input logic [W-1:0] d);
      req_valid[i]       = v;
      req_last[i]        = l;
      req_data[i*W +: W] = d;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Granted beat on the FIFO port with wready high.
   task automatic chk_beat(input string tag, input int g, input logic [W-1:0] d);
      chk({tag, "_gnt"},   32'(gnt_idx), 32'(g));
      chk({tag, "_busy"},  32'(busy), 32'd1);
      chk({tag, "_wval"},  32'(fifo_wvalid), 32'd1);
      chk({tag, "_wdata"}, 32'(fifo_wdata), 32'(d));
      chk({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << g));
   endtask

   // Inter-packet IDLE cycle.
   task automatic chk_bubble(input string tag);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_wval"},  32'(fifo_wvalid), 32'd0);
      chk({tag, "_wdata"}, 32'(fifo_wdata), 32'd0);
      chk({tag, "_ready"}, 32'(req_ready), 32'd0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_bubble(tag);
      chk({tag, "_gnt"},   32'(gnt_idx), 32'd0);
      chk({tag, "_clr"},   32'(fifo_clr), 32'd0);
      chk({tag, "_state"}, 32'(state), 32'(ARB_IDLE));
      chk({tag, "_pkt"},   32'(pkt_cnt), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_i       = 1'b1;
      clr_i       = 1'b0;
      req_valid   = '0;
      req_last    = '0;
      req_data    = '0;
      fifo_wready = 1'b1;
      step();
      step();
      settle();
      chk_reset_vals("rst");
      rst_i = 1'b0;

      // Rotation: everyone requests single-beat packets.
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 16'(16'hA0 + i));
      settle();
      chk_bubble("rot_pre");
      for (int k = 0; k < 5; k++) begin
         step();
         settle();
         chk_beat($sformatf("rot%0d", k), k % NR, 16'(16'hA0 + (k % NR)));
         step();
         if (k == 4) req_valid = '0;
         settle();
         chk_bubble($sformatf("rot%0d_gap", k));
      end
      chk("rot_pkt", 32'(pkt_cnt), 32'd5);
      step();
      settle();
      chk("idle_noreq_busy", 32'(busy), 32'd0);

      // Packet lock: requester 2 (3 beats) beats requester 0 from pointer 1.
      set_req(2, 1'b1, 1'b0, 16'h1111);
      set_req(0, 1'b1, 1'b1, 16'h00B0);
      step();
      settle();
      chk_beat("lock1", 2, 16'h1111);
      step();
      set_req(2, 1'b1, 1'b0, 16'h2222);
      settle();
      chk_beat("lock2", 2, 16'h2222);
      step();
      set_req(2, 1'b1, 1'b1, 16'h3333);
      settle();
      chk_beat("lock3", 2, 16'h3333);
      step();
      set_req(2, 1'b0, 1'b0, 16'h0000);
      settle();
      chk_bubble("lock_gap");
      step();
      settle();
      chk_beat("lock_next", 0, 16'h00B0);
      step();
      set_req(0, 1'b0, 1'b0, 16'h0000);
      settle();
      chk("lock_pkt", 32'(pkt_cnt), 32'd7);

      // Backpressure: requester 1, wready low for 5 cycles on the second beat.
      set_req(1, 1'b1, 1'b0, 16'h00C1);
      step();
      settle();
      chk_beat("bp1", 1, 16'h00C1);
      step();
      set_req(1, 1'b1, 1'b0, 16'h00C2);
      fifo_wready = 1'b0;
      for (int j = 0; j < 5; j++) begin
         settle();
         chk($sformatf("bp_stall%0d_wval", j),  32'(fifo_wvalid), 32'd1);
         chk($sformatf("bp_stall%0d_wdata", j), 32'(fifo_wdata), 32'h00C2);
         chk($sformatf("bp_stall%0d_ready", j), 32'(req_ready), 32'd0);
         step();
      end
      fifo_wready = 1'b1;
      settle();
      chk_beat("bp2", 1, 16'h00C2);
      step();
      set_req(1, 1'b1, 1'b1, 16'h00C3);
      settle();
      chk_beat("bp3", 1, 16'h00C3);
      step();
      set_req(1, 1'b0, 1'b0, 16'h0000);
      settle();
      chk_bubble("bp_gap");
      chk("bp_pkt", 32'(pkt_cnt), 32'd8);

      // Valid gap: requester 2 pauses for 2 cycles while 0 and 3 request.
      set_req(2, 1'b1, 1'b0, 16'h00D1);
      step();
      settle();
      chk_beat("gap1", 2, 16'h00D1);
      step();
      set_req(2, 1'b0, 1'b0, 16'h0000);
      set_req(0, 1'b1, 1'b1, 16'h00E0);
      set_req(3, 1'b1, 1'b1, 16'h00E3);
      for (int j = 0; j < 2; j++) begin
         settle();
         chk($sformatf("gap_hold%0d_busy", j),  32'(busy), 32'd1);
         chk($sformatf("gap_hold%0d_gnt", j),   32'(gnt_idx), 32'd2);
         chk($sformatf("gap_hold%0d_wval", j),  32'(fifo_wvalid), 32'd0);
         chk($sformatf("gap_hold%0d_wdata", j), 32'(fifo_wdata), 32'd0);
         chk($sformatf("gap_hold%0d_ready", j), 32'(req_ready), 32'b0100);
         step();
      end
      set_req(2, 1'b1, 1'b1, 16'h00D2);
      settle();
      chk_beat("gap2", 2, 16'h00D2);
      step();
      set_req(2, 1'b0, 1'b0, 16'h0000);
      settle();
      chk_bubble("gap_rel");
      step();
      settle();
      chk_beat("gap_next", 3, 16'h00E3);
      step();
      set_req(3, 1'b0, 1'b0, 16'h0000);
      set_req(0, 1'b0, 1'b0, 16'h0000);
      settle();
      chk("gap_pkt", 32'(pkt_cnt), 32'd10);

      // Flush against a last-beat handshake of requester 2.
      set_req(2, 1'b1, 1'b1, 16'h00F2);
      step();
      settle();
      chk_beat("fl_lock", 2, 16'h00F2);
      set_req(0, 1'b1, 1'b1, 16'h00E0);
      set_req(3, 1'b1, 1'b1, 16'h00E3);
      clr_i = 1'b1;
      settle();
      chk("fl_cyc_wval",  32'(fifo_wvalid), 32'd0);
      chk("fl_cyc_ready", 32'(req_ready), 32'd0);
      chk("fl_cyc_wdata", 32'(fifo_wdata), 32'd0);
      step();
      clr_i = 1'b0;
      set_req(2, 1'b0, 1'b0, 16'h0000);
      settle();
      chk("fl_clr_hi", 32'(fifo_clr), 32'd1);
      chk("fl_busy",   32'(busy), 32'd0);
      chk("fl_gnt",    32'(gnt_idx), 32'd0);
      chk("fl_pkt",    32'(pkt_cnt), 32'd10);
      step();
      settle();
      chk("fl_clr_lo", 32'(fifo_clr), 32'd0);
      chk_beat("fl_next", 0, 16'h00E0);
      step();
      set_req(0, 1'b0, 1'b0, 16'h0000);
      set_req(3, 1'b0, 1'b0, 16'h0000);
      settle();
      chk("fl_pkt2", 32'(pkt_cnt), 32'd11);

      // Asynchronous reset in the middle of a packet from requester 1.
      set_req(1, 1'b1, 1'b0, 16'h7777);
      step();
      settle();
      chk_beat("ar_lock", 1, 16'h7777);
      #2;
      rst_i = 1'b1;
      #1;
      chk_reset_vals("ar");
      set_req(1, 1'b0, 1'b0, 16'h0000);
      step();
      rst_i = 1'b0;
      step();
      settle();
      chk("ar_after_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_fifo_wr_arbiter.md
# spi_fifo_wr_arbiter

Packet-locking round-robin arbiter that lets several producers in the SPI peripheral share the write port of one synchronous FIFO. Producers include the register-file TX path, the DMA engine and the command sequencer. The block grants one requester at a time and holds the grant until that requester's last beat is accepted, so packets never interleave in the FIFO. It also exposes a synchronous flush that clears both the arbitration state and the downstream FIFO.

## Interface
Parameters:
- NumReq, 4: number of requesters; must be ≥ 2.
- Width, 16: data width; matches the FIFO Width.
- IdxW, derived: max(1, $clog2(NumReq)).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous assert, active-high.
- clr_i  in  1  synchronous flush; highest priority.
- req_valid_i  in  NumReq  per-requester beat valid.
- req_last_i  in  NumReq  per-requester last-beat-of-packet flag; qualified by valid.
- req_data_i  in  NumReq×Width  per-requester data, packed, requester 0 in the LSBs.
- req_ready_o  out  NumReq  per-requester ready; one-hot or zero.
- fifo_wvalid_o  out  1  to FIFO wvalid.
- fifo_wready_i  in  1  from FIFO wready.
- fifo_wdata_o  out  Width  to FIFO wdata.
- fifo_clr_o  out  1  to FIFO clr; one-cycle pulse.
- gnt_idx_o  out  IdxW  index of the current or last granted requester.
- busy_o  out  1  high while in LOCKED.

## Operation
- The FSM has two states, IDLE and LOCKED; reset state is IDLE.
- **IDLE:**
  - All req_ready_o and fifo_wvalid_o are 0.
  - If any req_valid_i is set, pick the winner by round robin. Search starts at prio_ptr and rises with wrap-around (prio_ptr, prio_ptr+1, …, NumReq-1, 0, …).
  - Register the winner into gnt_idx and go to LOCKED.
  - If no request is present, stay in IDLE.
- **LOCKED:**
  - fifo_wvalid_o = req_valid_i[gnt_idx].
  - fifo_wdata_o = req_data_i[gnt_idx].
  - req_ready_o[gnt_idx] = fifo_wready_i; all other ready bits are 0.
  - A beat is accepted when fifo_wvalid_o & fifo_wready_i.
- **Release:**
  - An accepted beat with req_last_i[gnt_idx]=1 moves the FSM to IDLE.
  - On release, prio_ptr = gnt_idx+1, wrapping to 0 after NumReq-1.
  - On release, pkt_cnt increments.
- **Grant hold:**
  - If the granted requester drops valid mid-packet, the grant is held and fifo_wvalid_o goes to 0.
  - There is no timeout.
  - Other requesters are never served until release.
- **Data when idle:** fifo_wdata_o is 0 whenever fifo_wvalid_o is 0, so no X is propagated.
- **Flush (clr_i):**
  - Overrides everything: next state IDLE, prio_ptr = 0, gnt_idx = 0.
  - fifo_clr_o = 1 in the cycle after clr_i is sampled. It is registered, one pulse per clr_i cycle.
  - While clr_i = 1, all req_ready_o = 0 and fifo_wvalid_o = 0. No beat is accepted in that cycle.
- **Reset values:** state IDLE, prio_ptr 0, gnt_idx_o 0, req_ready_o 0, fifo_wvalid_o 0, fifo_wdata_o 0, fifo_clr_o 0, busy_o 0.
- **Reset mid-packet:** the packet is abandoned. Downstream must also be reset or flushed; the partial packet is not rolled back.

## Timing
- Arbitration latency: 1 cycle. A request sampled in IDLE at edge N makes the first beat presentable in cycle N+1.
- Throughput inside a packet: 1 beat per cycle while valid & wready.
- Inter-packet bubble: exactly 1 IDLE cycle after each release, including between back-to-back packets from the same requester.
- A single-beat packet (last on the first beat) takes 2 cycles minimum.
- FIFO full: fifo_wready_i = 0 stalls the beat; valid, data and last must be held by the requester (AXI-style rule).
- Simultaneous clr_i and a last-beat handshake: clr wins. The beat is not accepted and the pointer resets to 0.

## Structure
- Package spi_arb_pkg holds:
  - the state enum typedef (IDLE, LOCKED);
  - a function computing IdxW from NumReq.
- One sub-module, spi_rr_picker: combinational. Inputs req vector and prio_ptr; outputs winner index and any_req.
  - Implemented as a double-width masked priority encoder.
- The top level holds the FSM, prio_ptr, gnt_idx, the clr pulse register and the output muxes.

## Test plan
- **Rotation:** reset, then all 4 requesters hold valid with single-beat packets (last=1), data 0xA0+i, wready=1. Required: grants in order 0,1,2,3,0; FIFO receives A0,A1,A2,A3,A0; one bubble between each.
- **Packet lock:** requester 2 sends 3 beats (0x1111, 0x2222, 0x3333, last on the third) while requester 0 is also valid. Required: the three beats are contiguous, req_ready_o[0]=0 throughout, and requester 0 is granted next.
- **Backpressure:** fifo_wready_i low for 5 cycles mid-packet. Required: fifo_wvalid_o stays 1, data is stable, no ready is asserted, and the packet resumes with no loss or duplication.
- **Valid gap:** the granted requester deasserts valid for 2 cycles mid-packet while others request. Required: the grant is held, busy_o=1, fifo_wvalid_o=0.
- **Flush during LOCKED:** pulse clr_i together with a last-beat handshake. Required: the beat is not accepted, fifo_clr_o=1 for exactly one cycle, then IDLE, and the next grant starts search from requester 0.
- **Async reset:** assert rst_i mid-cycle during a packet. Required: all outputs drop to their reset values immediately, without waiting for a clock edge.
